// File: rtl/sha256_iter_ctrl_if.sv
// Block-in / digest-out handshake bundle for the iterative SHA-256 engine.
// The master side is the upstream producer/consumer; the engine takes the slave modport.
interface sha256_iter_ctrl_if;
   localparam int unsigned BLK_W = 512;
   localparam int unsigned DIG_W = 256;

   logic [BLK_W-1:0] blk_data;
   logic             blk_first;
   logic             blk_last;
   logic             blk_valid;
   logic             blk_ready;
   logic [DIG_W-1:0] digest;
   logic             digest_valid;
   logic             digest_ready;
   logic             busy;

   modport master (
      output blk_data, blk_first, blk_last, blk_valid, digest_ready,
      input  blk_ready, digest, digest_valid, busy
   );

   modport slave (
      input  blk_data, blk_first, blk_last, blk_valid, digest_ready,
      output blk_ready, digest, digest_valid, busy
   );
endinterface

// File: rtl/sha256_iter_ctrl.sv
// Iterative SHA-256 compression: one round per clock, multi-block chaining through H,
// digest returned over a valid/ready handshake.
module sha256_iter_ctrl #(
   parameter int unsigned ROUNDS = 64
) (
   input logic              clk,
   input logic              rst_n,
   sha256_iter_ctrl_if.slave bus
);
   localparam int unsigned WORD_W = 32;
   localparam int unsigned T_W    = 6;
   localparam logic [255:0] IV =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

   typedef enum logic [1:0] {S_IDLE, S_ROUND, S_UPDATE, S_DONE} state_e;

   state_e             state_q, state_d;
   logic [T_W-1:0]     t_q, t_d;
   logic               last_q, last_d;
   logic               chain_q, chain_d;
   logic [WORD_W-1:0]  w_q [16];
   logic [WORD_W-1:0]  w_d [16];
   logic [WORD_W-1:0]  v_q [8];
   logic [WORD_W-1:0]  v_d [8];
   logic [WORD_W-1:0]  h_q [8];
   logic [WORD_W-1:0]  h_d [8];
   logic               blk_ready_q, digest_valid_q, busy_q;
   logic               accept_c;
   logic [WORD_W-1:0]  k_c, t1_c, t2_c, w_new_c;

   function automatic logic [WORD_W-1:0] bsig0(input logic [WORD_W-1:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic logic [WORD_W-1:0] bsig1(input logic [WORD_W-1:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   function automatic logic [WORD_W-1:0] ssig0(input logic [WORD_W-1:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [WORD_W-1:0] ssig1(input logic [WORD_W-1:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   // Round-constant ROM indexed by the round counter
   function automatic logic [WORD_W-1:0] k_rom(input logic [T_W-1:0] t);
      logic [WORD_W-1:0] k;
      k = '0;
      case (t)
         6'd0:  k = 32'h428a2f98; 6'd1:  k = 32'h71374491; 6'd2:  k = 32'hb5c0fbcf; 6'd3:  k = 32'he9b5dba5;
         6'd4:  k = 32'h3956c25b; 6'd5:  k = 32'h59f111f1; 6'd6:  k = 32'h923f82a4; 6'd7:  k = 32'hab1c5ed5;
         6'd8:  k = 32'hd807aa98; 6'd9:  k = 32'h12835b01; 6'd10: k = 32'h243185be; 6'd11: k = 32'h550c7dc3;
         6'd12: k = 32'h72be5d74; 6'd13: k = 32'h80deb1fe; 6'd14: k = 32'h9bdc06a7; 6'd15: k = 32'hc19bf174;
         6'd16: k = 32'he49b69c1; 6'd17: k = 32'hefbe4786; 6'd18: k = 32'h0fc19dc6; 6'd19: k = 32'h240ca1cc;
         6'd20: k = 32'h2de92c6f; 6'd21: k = 32'h4a7484aa; 6'd22: k = 32'h5cb0a9dc; 6'd23: k = 32'h76f988da;
         6'd24: k = 32'h983e5152; 6'd25: k = 32'ha831c66d; 6'd26: k = 32'hb00327c8; 6'd27: k = 32'hbf597fc7;
         6'd28: k = 32'hc6e00bf3; 6'd29: k = 32'hd5a79147; 6'd30: k = 32'h06ca6351; 6'd31: k = 32'h14292967;
         6'd32: k = 32'h27b70a85; 6'd33: k = 32'h2e1b2138; 6'd34: k = 32'h4d2c6dfc; 6'd35: k = 32'h53380d13;
         6'd36: k = 32'h650a7354; 6'd37: k = 32'h766a0abb; 6'd38: k = 32'h81c2c92e; 6'd39: k = 32'h92722c85;
         6'd40: k = 32'ha2bfe8a1; 6'd41: k = 32'ha81a664b; 6'd42: k = 32'hc24b8b70; 6'd43: k = 32'hc76c51a3;
         6'd44: k = 32'hd192e819; 6'd45: k = 32'hd6990624; 6'd46: k = 32'hf40e3585; 6'd47: k = 32'h106aa070;
         6'd48: k = 32'h19a4c116; 6'd49: k = 32'h1e376c08; 6'd50: k = 32'h2748774c; 6'd51: k = 32'h34b0bcb5;
         6'd52: k = 32'h391c0cb3; 6'd53: k = 32'h4ed8aa4a; 6'd54: k = 32'h5b9cca4f; 6'd55: k = 32'h682e6ff3;
         6'd56: k = 32'h748f82ee; 6'd57: k = 32'h78a5636f; 6'd58: k = 32'h84c87814; 6'd59: k = 32'h8cc70208;
         6'd60: k = 32'h90befffa; 6'd61: k = 32'ha4506ceb; 6'd62: k = 32'hbef9a3f7; 6'd63: k = 32'hc67178f2;
         default: k = '0;
      endcase
      return k;
   endfunction

   // One compression round; w_q[0] always holds W[t], w_new_c is W[t+16]
   always_comb begin
      k_c     = k_rom(t_q);
      t1_c    = v_q[7] + bsig1(v_q[4]) + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + k_c + w_q[0];
      t2_c    = bsig0(v_q[0]) + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
      w_new_c = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
   end

   always_comb begin
      state_d  = state_q;
      t_d      = t_q;
      last_d   = last_q;
      chain_d  = chain_q;
      w_d      = w_q;
      v_d      = v_q;
      h_d      = h_q;
      accept_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.blk_valid) begin
               accept_c = 1'b1;
               for (int i = 0; i < 16; i++) w_d[i] = bus.blk_data[511 - 32*i -: 32];
               for (int i = 0; i < 8; i++) begin
                  v_d[i] = bus.blk_first ? IV[255 - 32*i -: 32] : h_q[i];
                  if (bus.blk_first) h_d[i] = IV[255 - 32*i -: 32];
               end
               last_d  = bus.blk_last;
               chain_d = 1'b1;
               t_d     = '0;
               state_d = S_ROUND;
            end
         end
         S_ROUND: begin
            for (int i = 0; i < 15; i++) w_d[i] = w_q[i+1];
            w_d[15] = w_new_c;
            v_d[0]  = t1_c + t2_c;
            v_d[1]  = v_q[0];
            v_d[2]  = v_q[1];
            v_d[3]  = v_q[2];
            v_d[4]  = v_q[3] + t1_c;
            v_d[5]  = v_q[4];
            v_d[6]  = v_q[5];
            v_d[7]  = v_q[6];
            t_d     = t_q + T_W'(1);
            if (t_q == T_W'(ROUNDS - 1)) state_d = S_UPDATE;
         end
         S_UPDATE: begin
            for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + v_q[i];
            chain_d = ~last_q;
            state_d = last_q ? S_DONE : S_IDLE;
         end
         S_DONE: begin
            if (bus.digest_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         t_q            <= '0;
         last_q         <= 1'b0;
         chain_q        <= 1'b0;
         for (int i = 0; i < 16; i++) w_q[i] <= '0;
         for (int i = 0; i < 8; i++) begin
            v_q[i] <= '0;
            h_q[i] <= IV[255 - 32*i -: 32];
         end
         blk_ready_q    <= 1'b1;
         digest_valid_q <= 1'b0;
         busy_q         <= 1'b0;
      end else begin
         state_q        <= state_d;
         t_q            <= t_d;
         last_q         <= last_d;
         chain_q        <= chain_d;
         w_q            <= w_d;
         v_q            <= v_d;
         h_q            <= h_d;
         blk_ready_q    <= (state_d == S_IDLE);
         digest_valid_q <= (state_d == S_DONE);
         busy_q         <= (state_d != S_IDLE);
      end
   end

   assign bus.blk_ready    = blk_ready_q;
   assign bus.digest_valid = digest_valid_q;
   assign bus.busy         = busy_q;
   assign bus.digest       = {h_q[0], h_q[1], h_q[2], h_q[3], h_q[4], h_q[5], h_q[6], h_q[7]};

   // A continuation block must only arrive while a message is still open
   a_first_needs_chain: assert property (@(posedge clk) disable iff (!rst_n)
      accept_c |-> (bus.blk_first || chain_q));

   a_round_range: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == S_ROUND) |-> (32'(t_q) < ROUNDS));
endmodule

// File: tb/tb_sha256_iter_ctrl.sv
// Bench for sha256_iter_ctrl: reference SHA-256 model plus cycle-level handshake model,
// compared against the DUT every cycle, with known-answer digests pinning the model.
module tb_sha256_iter_ctrl;
   localparam logic [255:0] IV =
      256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
   localparam logic [255:0] ABC_D =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] EMPTY_D =
      256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
   localparam logic [255:0] TWO_D =
      256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
   localparam logic [31:0] KT [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   logic chk_en = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   sha256_iter_ctrl_if bus();

   sha256_iter_ctrl #(.ROUNDS(64)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] blk);
      logic [31:0]  w [64];
      logic [31:0]  s [8];
      logic [31:0]  t1, t2;
      logic [255:0] r;
      for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
      for (int i = 16; i < 64; i++)
         w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
              + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
      for (int i = 0; i < 8; i++) s[i] = hin[255 - 32*i -: 32];
      for (int i = 0; i < 64; i++) begin
         t1 = s[7] + (rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25))
            + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KT[i] + w[i];
         t2 = (rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22))
            + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
         s[7] = s[6]; s[6] = s[5]; s[5] = s[4]; s[4] = s[3] + t1;
         s[3] = s[2]; s[2] = s[1]; s[1] = s[0]; s[0] = t1 + t2;
      end
      for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = hin[255 - 32*i -: 32] + s[i];
      return r;
   endfunction

   // Single-block padding for messages of at most 55 bytes
   function automatic logic [511:0] pad(input string msg);
      logic [511:0] b;
      int n;
      b = '0;
      n = msg.len();
      for (int i = 0; i < n; i++) b[511 - 8*i -: 8] = msg[i];
      b[511 - 8*n -: 8] = 8'h80;
      b[63:0] = 64'(n * 8);
      return b;
   endfunction

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Transaction-level model: an accepted block keeps the engine busy for 65 edges
   typedef enum {M_IDLE, M_BUSY, M_DONE} mph_e;
   mph_e         m_ph;
   int           m_cnt;
   logic         m_last;
   logic [255:0] m_h, m_pend;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ph   <= M_IDLE;
         m_cnt  <= 0;
         m_last <= 1'b0;
         m_h    <= IV;
         m_pend <= IV;
      end else begin
         case (m_ph)
            M_IDLE: if (bus.blk_valid) begin
               m_pend <= sha_compress(bus.blk_first ? IV : m_h, bus.blk_data);
               m_last <= bus.blk_last;
               m_cnt  <= 65;
               m_ph   <= M_BUSY;
            end
            M_BUSY: if (m_cnt == 1) begin
               m_h  <= m_pend;
               m_ph <= m_last ? M_DONE : M_IDLE;
            end else begin
               m_cnt <= m_cnt - 1;
            end
            default: if (bus.digest_ready) m_ph <= M_IDLE;
         endcase
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("blk_ready", 256'(bus.blk_ready), 256'(m_ph == M_IDLE));
         chk("busy", 256'(bus.busy), 256'(m_ph != M_IDLE));
         chk("digest_valid", 256'(bus.digest_valid), 256'(m_ph == M_DONE));
         if (m_ph == M_DONE) chk("digest", bus.digest, m_h);
         if (!rst_n) chk("digest_in_reset", bus.digest, IV);
      end
   end

   // Starts and ends on a falling edge; returns right after the accept edge
   task automatic send_block(input logic [511:0] data, input logic first, input logic last);
      int n;
      bus.blk_data  = data;
      bus.blk_first = first;
      bus.blk_last  = last;
      bus.blk_valid = 1'b1;
      n = 0;
      while (!bus.blk_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("accept_timeout", 256'(bus.blk_ready), 256'(1));
      @(posedge clk);
      @(negedge clk);
      bus.blk_valid = 1'b0;
   endtask

   task automatic wait_digest(input string name, input logic [255:0] exp, input bit chk_lat);
      int n;
      n = 0;
      while (!bus.digest_valid && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk({name, "_valid"}, 256'(bus.digest_valid), 256'(1));
      if (chk_lat) chk({name, "_latency"}, 256'(n), 256'(65));
      chk({name, "_digest"}, bus.digest, exp);
   endtask

   initial begin
      logic [511:0] b1, b2, hb;
      logic [255:0] hd;
      b1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667, 32'h65666768, 32'h66676869,
            32'h6768696a, 32'h68696a6b, 32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
            32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
      b2 = {448'h0, 64'h1c0};
      hb = pad("Hello, SHA-256!");
      hd = sha_compress(IV, hb);

      bus.blk_data     = '0;
      bus.blk_first    = 1'b0;
      bus.blk_last     = 1'b0;
      bus.blk_valid    = 1'b0;
      bus.digest_ready = 1'b1;
      #1 rst_n = 1'b0;
      #1 chk_en = 1'b1;

      chk("model_abc", sha_compress(IV, pad("abc")), ABC_D);
      chk("model_empty", sha_compress(IV, pad("")), EMPTY_D);
      chk("model_two_block", sha_compress(sha_compress(IV, b1), b2), TWO_D);

      repeat (2) @(negedge clk);
      chk("rst_blk_ready", 256'(bus.blk_ready), 256'(1));
      chk("rst_busy", 256'(bus.busy), 256'(0));
      chk("rst_digest_valid", 256'(bus.digest_valid), 256'(0));
      chk("rst_digest", bus.digest, IV);
      #2 rst_n = 1'b1;
      @(negedge clk);

      send_block(pad("abc"), 1'b1, 1'b1);
      wait_digest("abc", ABC_D, 1'b1);

      send_block(pad(""), 1'b1, 1'b1);
      wait_digest("empty", EMPTY_D, 1'b1);

      send_block(hb, 1'b1, 1'b1);
      wait_digest("hello", hd, 1'b1);
      send_block(pad("abc"), 1'b1, 1'b1);
      wait_digest("abc_after_hello", ABC_D, 1'b1);

      // Second block presented early while the first is still running
      send_block(b1, 1'b1, 1'b0);
      repeat (10) @(negedge clk);
      send_block(b2, 1'b0, 1'b1);
      wait_digest("two_block", TWO_D, 1'b1);

      // Consumer stall with a block waiting upstream
      @(negedge clk);
      bus.digest_ready = 1'b0;
      send_block(pad("abc"), 1'b1, 1'b1);
      wait_digest("stall", ABC_D, 1'b1);
      bus.blk_data  = pad("xyz");
      bus.blk_first = 1'b1;
      bus.blk_last  = 1'b1;
      bus.blk_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("stall_digest_hold", bus.digest, ABC_D);
         chk("stall_blk_ready", 256'(bus.blk_ready), 256'(0));
      end
      bus.blk_valid    = 1'b0;
      bus.digest_ready = 1'b1;
      @(negedge clk);
      chk("stall_release_valid", 256'(bus.digest_valid), 256'(0));
      chk("stall_release_ready", 256'(bus.blk_ready), 256'(1));

      // Reset in the middle of a message
      send_block(pad("abc"), 1'b1, 1'b1);
      repeat (30) @(negedge clk);
      #2 rst_n = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk("midrst_blk_ready", 256'(bus.blk_ready), 256'(1));
         chk("midrst_busy", 256'(bus.busy), 256'(0));
         chk("midrst_digest_valid", 256'(bus.digest_valid), 256'(0));
      end
      #2 rst_n = 1'b1;
      repeat (40) @(negedge clk);
      chk("midrst_no_digest", 256'(bus.digest_valid), 256'(0));
      send_block(pad("abc"), 1'b1, 1'b1);
      wait_digest("abc_after_reset", ABC_D, 1'b1);

      repeat (3) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
